// File: rtl/lcd_line_fmt_if.sv
// Character stream from the line formatter to the LCD write engine.
// valid/ready handshake; char_last marks the final character of a line.
interface lcd_line_fmt_if #(
  parameter int CHAR_W = 7
);
  logic [CHAR_W-1:0] char_data;
  logic              char_valid;
  logic              char_ready;
  logic              char_last;

  modport master (
    output char_data,
    output char_valid,
    output char_last,
    input  char_ready
  );

  modport slave (
    input  char_data,
    input  char_valid,
    input  char_last,
    output char_ready
  );
endinterface

// File: rtl/lcd_line_fmt.sv
// Streams one fixed-length ASCII price line per start; first char valid the cycle after start.
// One char per cycle at full ready; while char_ready is low the current char and char_last hold.
module lcd_line_fmt #(
  parameter int PRICE_DIGITS = 4,
  parameter int FRAC_DIGITS  = 2,
  parameter int LINE_LEN     = 16,
  parameter int CHAR_W       = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode_i,
  input  logic [3:0]                qty_i,
  input  logic [4*PRICE_DIGITS-1:0] price_i,
  input  logic                      blank_lz_i,
  lcd_line_fmt_if.master            char_if,
  output logic                      busy,
  output logic                      done,
  output logic                      bcd_err
);

  localparam bit       HAS_DOT     = (FRAC_DIGITS > 0);
  localparam int       INT_DIGITS  = PRICE_DIGITS - FRAC_DIGITS;
  localparam int       PRICE_CHARS = PRICE_DIGITS + (HAS_DOT ? 1 : 0);
  localparam int       POS_W       = $clog2(LINE_LEN);
  localparam logic [3:0] SUB_DOT       = 4'(INT_DIGITS);
  localparam logic [3:0] SUB_PRICE_END = 4'(PRICE_CHARS - 1);
  localparam logic [3:0] SUB_LZ_END    = 4'(INT_DIGITS - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(LINE_LEN - 1);

  if (PRICE_DIGITS < 2 || PRICE_DIGITS > 8) begin : g_bad_price_digits
    $error("lcd_line_fmt: PRICE_DIGITS must be in 2..8");
  end
  if (FRAC_DIGITS < 0 || FRAC_DIGITS >= PRICE_DIGITS) begin : g_bad_frac_digits
    $error("lcd_line_fmt: FRAC_DIGITS must be below PRICE_DIGITS");
  end
  if (4 + PRICE_CHARS + 1 > LINE_LEN) begin : g_bad_line_len
    $error("lcd_line_fmt: LINE_LEN too short for a total line");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFIX,
    S_PRICE,
    S_SUFFIX,
    S_PAD
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [POS_W-1:0]          pos;
  logic [3:0]                sub;
  logic                      mode_q;
  logic [3:0]                qty_q;
  logic [4*PRICE_DIGITS-1:0] price_q;
  logic                      blank_q;
  logic                      lz_q;
  logic                      err_in;
  logic [6:0]                ch;
  logic [3:0]                dig;
  logic                      is_dot;
  logic                      xfer;
  logic                      at_last;
  logic                      pre_end;

  assign busy               = (state != S_IDLE);
  assign char_if.char_valid = busy;
  assign at_last            = (pos == LAST_POS);
  assign char_if.char_last  = busy && at_last;
  assign char_if.char_data  = CHAR_W'(ch);
  assign xfer               = busy && char_if.char_ready;

  // price_q shifts left per emitted digit, so the current digit is always the top nibble
  assign dig     = price_q[4*PRICE_DIGITS-1 -: 4];
  assign is_dot  = HAS_DOT && (sub == SUB_DOT);
  assign pre_end = mode_q ? (sub == 4'd3) : (sub == 4'd1);

  always_comb begin
    err_in = !mode_i && (qty_i > 4'd9);
    for (int i = 0; i < PRICE_DIGITS; i++) begin
      if (price_i[4*i +: 4] > 4'd9) err_in = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ch        = 7'h20;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_PREFIX;
      end
      S_PREFIX: begin
        if (mode_q) begin
          case (sub[1:0])
            2'd0:    ch = 7'h54;
            2'd1:    ch = 7'h4F;
            2'd2:    ch = 7'h54;
            default: ch = 7'h3A;
          endcase
        end else if (sub == 4'd0) begin
          ch = (qty_q > 4'd9) ? 7'h3F : {3'b011, qty_q};
        end
        if (xfer && pre_end) state_nxt = S_PRICE;
      end
      S_PRICE: begin
        if (is_dot)
          ch = 7'h2E;
        else if (dig > 4'd9)
          ch = 7'h3F;
        else if (blank_q && lz_q && (dig == 4'd0) && (sub < SUB_LZ_END))
          ch = 7'h20;
        else
          ch = {3'b011, dig};
        if (xfer && (sub == SUB_PRICE_END)) state_nxt = S_SUFFIX;
      end
      S_SUFFIX: begin
        ch = 7'h24;
        if (xfer) state_nxt = S_PAD;
      end
      S_PAD: begin
        ch = 7'h20;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // a line may end in SUFFIX when there is no room left for padding
    if (xfer && at_last) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pos     <= '0;
      sub     <= '0;
      done    <= 1'b0;
      bcd_err <= 1'b0;
      mode_q  <= 1'b0;
      qty_q   <= '0;
      price_q <= '0;
      blank_q <= 1'b0;
      lz_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= xfer && at_last;
      if (state == S_IDLE) begin
        if (start) begin
          mode_q  <= mode_i;
          qty_q   <= qty_i;
          price_q <= price_i;
          blank_q <= blank_lz_i;
          lz_q    <= 1'b1;
          bcd_err <= err_in;
          pos     <= '0;
          sub     <= '0;
        end
      end else if (xfer) begin
        pos <= pos + 1'b1;
        sub <= (state_nxt != state) ? 4'd0 : sub + 4'd1;
        if ((state == S_PRICE) && !is_dot) begin
          price_q <= price_q << 4;
          // '?' counts as nonzero, ending the blanked run
          if (dig != 4'd0) lz_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_line_fmt.sv
// Bench for lcd_line_fmt: default build plus a 6-digit, no-fraction, 12-char build.
module tb_lcd_line_fmt;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2, mode, blank, rdy;
  logic [3:0]  qty;
  logic [15:0] price;
  logic [23:0] price2;
  logic        busy, done, bcd_err, busy2, done2, bcd_err2;

  lcd_line_fmt_if #(.CHAR_W(7)) cif  ();
  lcd_line_fmt_if #(.CHAR_W(7)) cif2 ();
  assign cif.char_ready  = rdy;
  assign cif2.char_ready = rdy;

  lcd_line_fmt #(.PRICE_DIGITS(4), .FRAC_DIGITS(2), .LINE_LEN(16), .CHAR_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_i(mode), .qty_i(qty), .price_i(price),
    .blank_lz_i(blank), .char_if(cif), .busy(busy), .done(done), .bcd_err(bcd_err)
  );

  lcd_line_fmt #(.PRICE_DIGITS(6), .FRAC_DIGITS(0), .LINE_LEN(12), .CHAR_W(7)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode_i(mode), .qty_i(qty), .price_i(price2),
    .blank_lz_i(blank), .char_if(cif2), .busy(busy2), .done(done2), .bcd_err(bcd_err2)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard entries are {char_last, char_data}
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] obs2_q[$];
  int         obs_cyc[$];
  int         done_cnt = 0, done2_cnt = 0, done_cyc = 0, stall_viol = 0;
  bit         stalled = 1'b0;
  logic [7:0] stall_val = '0;

  always @(negedge clk) begin
    if (cif.char_valid && rdy) begin
      obs_q.push_back({cif.char_last, cif.char_data});
      obs_cyc.push_back(cyc);
    end
    if (cif2.char_valid && rdy) obs2_q.push_back({cif2.char_last, cif2.char_data});
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (done2) done2_cnt++;
    if (stalled && cif.char_valid && ({cif.char_last, cif.char_data} != stall_val)) stall_viol++;
    stalled   = cif.char_valid && !rdy && !rst;
    stall_val = {cif.char_last, cif.char_data};
  end

  task automatic push_exp(input string s, input int len, input bit mark_last);
    byte        b;
    logic [6:0] c;
    for (int i = 0; i < len; i++) begin
      c = 7'h20;
      if (i < s.len()) begin
        b = s[i];
        c = b[6:0];
      end
      exp_q.push_back({mark_last && (i == len - 1), c});
    end
  endtask

  task automatic start_line(input logic m, input logic [3:0] q, input logic [15:0] p,
                            input logic b, output int sc);
    obs_q.delete();
    obs_cyc.delete();
    mode = m; qty = q; price = p; blank = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m; qty = 4'($urandom); price = 16'($urandom); blank = ~b;
    sc = cyc;
  endtask

  task automatic wait_done(input bit second, input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if ((second ? done2_cnt : done_cnt) != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0; rdy = 1'b0;
    mode = 1'b0; qty = '0; price = '0; price2 = '0; blank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cif.char_valid, cif.char_last, busy, done, bcd_err} !== 5'b0)
      $display("FAIL reset_flags got=%b want=00000", {cif.char_valid, cif.char_last, busy, done, bcd_err});
    checks++;
    if (cif.char_data !== 7'h20) begin
      $display("FAIL reset_char_data got=%h want=20", cif.char_data); failures++;
    end
    checks++;
    if ({cif2.char_valid, busy2, done2, bcd_err2, cif2.char_data} !== {4'b0, 7'h20}) begin
      $display("FAIL reset_dut2 got=%b want=00000100000", {cif2.char_valid, busy2, done2, bcd_err2, cif2.char_data});
      failures++;
    end
    if ({cif.char_valid, cif.char_last, busy, done, bcd_err} !== 5'b0) failures++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_item_line();
    int sc, d0, k, oc, last_c;
    bit ok;
    logic [7:0] e, o;
    rdy = 1'b1; d0 = done_cnt; last_c = 0;
    push_exp("3 12.34$", 16, 1'b1);
    start_line(1'b0, 4'd3, 16'h1234, 1'b0, sc);
    wait_done(1'b0, d0, ok);
    checks++;
    if (!ok) begin $display("FAIL item_done_timeout got=none want=done"); failures++; end
    checks++;
    if (obs_q.size() != 16) begin $display("FAIL item_count got=%0d want=16", obs_q.size()); failures++; end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 'x; oc = -1;
      if (obs_q.size() > 0) begin o = obs_q.pop_front(); oc = obs_cyc.pop_front(); end
      checks++;
      if (o !== e || oc !== sc + k) begin
        $display("FAIL item_char%0d got=%h@%0d want=%h@%0d", k, o, oc, e, sc + k); failures++;
      end
      last_c = oc; k++;
    end
    checks++;
    if (done_cyc !== last_c + 1) begin $display("FAIL item_done_cycle got=%0d want=%0d", done_cyc, last_c + 1); failures++; end
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1 || busy !== 1'b0 || bcd_err !== 1'b0) begin
      $display("FAIL item_after got=%0d/%b/%b want=%0d/0/0", done_cnt - d0, busy, bcd_err, 1); failures++;
    end
  endtask

  task automatic test_total_blank();
    string s_tab[2];
    int sc, d0, k;
    bit ok;
    logic [7:0] e, o;
    s_tab[0] = "TOT: 0.50$";
    s_tab[1] = "TOT:00.50$";
    rdy = 1'b1;
    for (int t = 0; t < 2; t++) begin
      d0 = done_cnt;
      push_exp(s_tab[t], 16, 1'b1);
      start_line(1'b1, 4'd9, 16'h0050, (t == 0), sc);
      wait_done(1'b0, d0, ok);
      checks++;
      if (!ok || obs_q.size() != 16) begin
        $display("FAIL total%0d_count got=%0d want=16", t, obs_q.size()); failures++;
      end
      k = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = 'x;
        if (obs_q.size() > 0) o = obs_q.pop_front();
        checks++;
        if (o !== e) begin $display("FAIL total%0d_char%0d got=%h want=%h", t, k, o, e); failures++; end
        k++;
      end
      checks++;
      if (bcd_err !== 1'b0) begin $display("FAIL total%0d_bcd_err got=%b want=0", t, bcd_err); failures++; end
    end
  endtask

  task automatic test_bcd_err();
    string       s_tab[4];
    logic [3:0]  q_tab[4];
    logic [15:0] p_tab[4];
    bit          b_tab[4];
    bit          err_tab[4];
    int sc, d0, k;
    bit ok;
    logic [7:0] e, o;
    s_tab[0] = "1 12.?4$"; q_tab[0] = 4'd1;  p_tab[0] = 16'h12A4; b_tab[0] = 1'b0; err_tab[0] = 1'b1;
    s_tab[1] = "? 00.00$"; q_tab[1] = 4'hC;  p_tab[1] = 16'h0000; b_tab[1] = 1'b0; err_tab[1] = 1'b1;
    s_tab[2] = "5  0.07$"; q_tab[2] = 4'd5;  p_tab[2] = 16'h0007; b_tab[2] = 1'b1; err_tab[2] = 1'b0;
    s_tab[3] = "2 ?0.12$"; q_tab[3] = 4'd2;  p_tab[3] = 16'hA012; b_tab[3] = 1'b1; err_tab[3] = 1'b1;
    rdy = 1'b1;
    for (int t = 0; t < 4; t++) begin
      d0 = done_cnt;
      push_exp(s_tab[t], 16, 1'b1);
      start_line(1'b0, q_tab[t], p_tab[t], b_tab[t], sc);
      checks++;
      if (bcd_err !== err_tab[t]) begin
        $display("FAIL bcd%0d_err_early got=%b want=%b", t, bcd_err, err_tab[t]); failures++;
      end
      wait_done(1'b0, d0, ok);
      checks++;
      if (!ok || obs_q.size() != 16) begin
        $display("FAIL bcd%0d_count got=%0d want=16", t, obs_q.size()); failures++;
      end
      k = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = 'x;
        if (obs_q.size() > 0) o = obs_q.pop_front();
        checks++;
        if (o !== e) begin $display("FAIL bcd%0d_char%0d got=%h want=%h", t, k, o, e); failures++; end
        k++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bcd_err !== err_tab[t]) begin
        $display("FAIL bcd%0d_err_sticky got=%b want=%b", t, bcd_err, err_tab[t]); failures++;
      end
    end
  endtask

  task automatic test_backpressure();
    int sc, d0, k, last_c, c;
    logic [7:0] e, o;
    d0 = done_cnt; stall_viol = 0; last_c = 0;
    push_exp("3 12.34$", 16, 1'b1);
    rdy = 1'b0;
    start_line(1'b0, 4'd3, 16'h1234, 1'b0, sc);
    for (c = 0; c < 400 && done_cnt == d0; c++) begin
      rdy = (c < 8) ? (c % 2 == 0) : ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    checks++;
    if (done_cnt == d0) begin $display("FAIL bp_done_timeout got=none want=done"); failures++; end
    checks++;
    if (obs_q.size() != 16) begin $display("FAIL bp_count got=%0d want=16", obs_q.size()); failures++; end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 'x;
      if (obs_q.size() > 0) begin o = obs_q.pop_front(); last_c = obs_cyc.pop_front(); end
      checks++;
      if (o !== e) begin $display("FAIL bp_char%0d got=%h want=%h", k, o, e); failures++; end
      k++;
    end
    checks++;
    if (stall_viol != 0) begin $display("FAIL bp_stall_stable got=%0d want=0", stall_viol); failures++; end
    checks++;
    if (done_cyc !== last_c + 1) begin $display("FAIL bp_done_cycle got=%0d want=%0d", done_cyc, last_c + 1); failures++; end
  endtask

  task automatic test_start_busy_rst();
    int sc, d0, k;
    bit ok;
    logic [7:0] e, o;
    rdy = 1'b1; d0 = done_cnt;
    push_exp("3 12.", 5, 1'b0);
    start_line(1'b0, 4'd3, 16'h1234, 1'b0, sc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1; price = 16'h9999;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (cif.char_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL rst_mid got=%b%b want=00", cif.char_valid, busy); failures++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0 || obs_q.size() != 5) begin
      $display("FAIL rst_no_done got=%0d/%0d want=0/5", done_cnt - d0, obs_q.size()); failures++;
    end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin $display("FAIL partial_char%0d got=%h want=%h", k, o, e); failures++; end
      k++;
    end
    d0 = done_cnt;
    push_exp("7  9.99$", 16, 1'b1);
    start_line(1'b0, 4'd7, 16'h0999, 1'b1, sc);
    wait_done(1'b0, d0, ok);
    checks++;
    if (!ok || obs_q.size() != 16) begin $display("FAIL restart_count got=%0d want=16", obs_q.size()); failures++; end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin $display("FAIL restart_char%0d got=%h want=%h", k, o, e); failures++; end
      k++;
    end
  endtask

  task automatic test_params();
    int d0, k;
    bit ok;
    logic [7:0] e, o;
    rdy = 1'b1; d0 = done2_cnt;
    obs2_q.delete();
    push_exp("TOT:  1234$", 12, 1'b1);
    mode = 1'b1; blank = 1'b1; price2 = 24'h001234; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; price2 = 24'($urandom); blank = 1'b0;
    wait_done(1'b1, d0, ok);
    checks++;
    if (!ok || obs2_q.size() != 12) begin $display("FAIL p6_count got=%0d want=12", obs2_q.size()); failures++; end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 'x;
      if (obs2_q.size() > 0) o = obs2_q.pop_front();
      checks++;
      if (o !== e) begin $display("FAIL p6_char%0d got=%h want=%h", k, o, e); failures++; end
      k++;
    end
    checks++;
    if (bcd_err2 !== 1'b0 || busy2 !== 1'b0) begin
      $display("FAIL p6_after got=%b%b want=00", bcd_err2, busy2); failures++;
    end
  endtask

  initial begin
    test_reset();
    test_item_line();
    test_total_blank();
    test_bcd_err();
    test_backpressure();
    test_start_busy_rst();
    test_params();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
